// File: rtl/openmips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | openmips_pkg: MIPS32 opcodes, funct codes, ALU op and select codes.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package openmips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_PREF    = 6'b110011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_MOVZ = 6'b001010;
  localparam logic [5:0] FN_MOVN = 6'b001011;
  localparam logic [5:0] FN_SYNC = 6'b001111;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [7:0] EXE_ANDI_OP  = 8'b01011001;
  localparam logic [7:0] EXE_ORI_OP   = 8'b01011010;
  localparam logic [7:0] EXE_XORI_OP  = 8'b01011011;
  localparam logic [7:0] EXE_LUI_OP   = 8'b01011100;
  localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [7:0] EXE_SLLV_OP  = 8'b00000100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [7:0] EXE_SRLV_OP  = 8'b00000110;
  localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
  localparam logic [7:0] EXE_SRAV_OP  = 8'b00000111;
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b00001010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b00001011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
  localparam logic [7:0] EXE_SLTI_OP  = 8'b01010111;
  localparam logic [7:0] EXE_SLTIU_OP = 8'b01011000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b01010110;
  localparam logic [7:0] EXE_LW_OP    = 8'b11100011;

  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE       = 3'b011;
  localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;
  localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

  localparam logic [4:0] NOPRegAddr = 5'b00000;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_SEXT  = 3'd1,
    IMM_ZEXT  = 3'd2,
    IMM_LUI   = 3'd3,
    IMM_SHAMT = 3'd4
  } imm_sel_e;

endpackage
`default_nettype wire

// File: rtl/id_fwd_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_fwd_mux: one read port's operand select (RF / forward / imm) and   |
// | load-use hazard detection.                       Rev 1.0              |
// +----------------------------------------------------------------------+
module id_fwd_mux
  import openmips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]              addr_i,
  input  logic                    read_en_i,
  input  logic [DATA_W-1:0]       rf_data_i,
  input  logic [NUM_FWD-1:0]      fwd_wreg_i,
  input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]      fwd_pending_i,
  input  logic [DATA_W-1:0]       imm_i,
  output logic [DATA_W-1:0]       operand_o,
  output logic                    hazard_o
);

  logic [DATA_W-1:0] fwd_val;
  logic              fwd_pend;

  // Walk oldest to youngest so the lowest matching index is the last writer.
  always_comb begin
    fwd_val  = rf_data_i;
    fwd_pend = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_wreg_i[k] && (fwd_wd_i[k*5 +: 5] == addr_i)) begin
        fwd_val  = fwd_wdata_i[k*DATA_W +: DATA_W];
        fwd_pend = fwd_pending_i[k];
      end
    end
  end

  always_comb begin
    operand_o = fwd_val;
    hazard_o  = fwd_pend;
    if (!read_en_i) begin
      operand_o = imm_i;
      hazard_o  = 1'b0;
    end else if (addr_i == NOPRegAddr) begin
      operand_o = '0;
      hazard_o  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_issue: MIPS32 decode, operand forwarding, load-use stall and the   |
// | ID/EX pipeline register with valid/ready handshake.     Rev 1.0       |
// +----------------------------------------------------------------------+
module id_issue
  import openmips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_valid_i,
  input  logic [31:0]               pc_i,
  input  logic [31:0]               inst_i,
  output logic                      id_ready_o,
  output logic [4:0]                rf_raddr1_o,
  output logic [4:0]                rf_raddr2_o,
  input  logic [DATA_W-1:0]         rf_rdata1_i,
  input  logic [DATA_W-1:0]         rf_rdata2_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [5*NUM_FWD-1:0]      fwd_wd_i,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]        fwd_pending_i,
  input  logic                      ex_ready_i,
  input  logic                      flush_i,
  output logic                      ex_valid_o,
  output logic [7:0]                ex_aluop_o,
  output logic [2:0]                ex_alusel_o,
  output logic [DATA_W-1:0]         ex_reg1_o,
  output logic [DATA_W-1:0]         ex_reg2_o,
  output logic [4:0]                ex_wd_o,
  output logic                      ex_wreg_o,
  output logic                      ex_is_load_o,
  output logic [31:0]               ex_pc_o,
  output logic                      ex_invalid_o,
  output logic [15:0]               stall_cnt_o
);

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, sa;
  assign op = inst_i[31:26];
  assign rs = inst_i[25:21];
  assign rt = inst_i[20:16];
  assign rd = inst_i[15:11];
  assign sa = inst_i[10:6];
  assign fn = inst_i[5:0];

  logic [7:0] dec_aluop;
  logic [2:0] dec_alusel;
  logic       dec_r1, dec_r2, dec_wreg, dec_load, dec_inv, dec_movn, dec_movz;
  logic [4:0] dec_wd;
  imm_sel_e   dec_imm_sel;

  always_comb begin
    dec_aluop   = EXE_NOP_OP;
    dec_alusel  = EXE_RES_NOP;
    dec_r1      = 1'b0;
    dec_r2      = 1'b0;
    dec_wreg    = 1'b0;
    dec_load    = 1'b0;
    dec_inv     = 1'b0;
    dec_movn    = 1'b0;
    dec_movz    = 1'b0;
    dec_wd      = rd;
    dec_imm_sel = IMM_NONE;
    case (op)
      OP_SPECIAL: begin
        dec_r1   = 1'b1;
        dec_r2   = 1'b1;
        dec_wreg = 1'b1;
        case (fn)
          FN_OR:   begin dec_aluop = EXE_OR_OP;   dec_alusel = EXE_RES_LOGIC; end
          FN_AND:  begin dec_aluop = EXE_AND_OP;  dec_alusel = EXE_RES_LOGIC; end
          FN_XOR:  begin dec_aluop = EXE_XOR_OP;  dec_alusel = EXE_RES_LOGIC; end
          FN_NOR:  begin dec_aluop = EXE_NOR_OP;  dec_alusel = EXE_RES_LOGIC; end
          FN_SLLV: begin dec_aluop = EXE_SLLV_OP; dec_alusel = EXE_RES_SHIFT; end
          FN_SRLV: begin dec_aluop = EXE_SRLV_OP; dec_alusel = EXE_RES_SHIFT; end
          FN_SRAV: begin dec_aluop = EXE_SRAV_OP; dec_alusel = EXE_RES_SHIFT; end
          FN_ADDU: begin dec_aluop = EXE_ADDU_OP; dec_alusel = EXE_RES_ARITHMETIC; end
          FN_SUBU: begin dec_aluop = EXE_SUBU_OP; dec_alusel = EXE_RES_ARITHMETIC; end
          FN_SLT:  begin dec_aluop = EXE_SLT_OP;  dec_alusel = EXE_RES_ARITHMETIC; end
          FN_SLTU: begin dec_aluop = EXE_SLTU_OP; dec_alusel = EXE_RES_ARITHMETIC; end
          FN_MOVN: begin
            dec_aluop = EXE_MOVN_OP; dec_alusel = EXE_RES_MOVE;
            dec_wreg  = 1'b0;        dec_movn   = 1'b1;
          end
          FN_MOVZ: begin
            dec_aluop = EXE_MOVZ_OP; dec_alusel = EXE_RES_MOVE;
            dec_wreg  = 1'b0;        dec_movz   = 1'b1;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            dec_r1      = 1'b0;
            dec_imm_sel = IMM_SHAMT;
            dec_alusel  = EXE_RES_SHIFT;
            dec_aluop   = (fn == FN_SLL) ? EXE_SLL_OP :
                          (fn == FN_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
            // The all-zero word is the canonical NOP and must not write.
            dec_wreg    = (inst_i != 32'h0);
          end
          FN_SYNC: begin dec_r1 = 1'b0; dec_r2 = 1'b0; dec_wreg = 1'b0; end
          default: begin
            dec_r1 = 1'b0; dec_r2 = 1'b0; dec_wreg = 1'b0; dec_inv = 1'b1;
          end
        endcase
      end
      OP_ORI, OP_ANDI, OP_XORI, OP_LUI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        dec_r1   = 1'b1;
        dec_wreg = 1'b1;
        dec_wd   = rt;
        case (op)
          OP_ORI:   begin dec_aluop = EXE_ORI_OP;   dec_alusel = EXE_RES_LOGIC;      dec_imm_sel = IMM_ZEXT; end
          OP_ANDI:  begin dec_aluop = EXE_ANDI_OP;  dec_alusel = EXE_RES_LOGIC;      dec_imm_sel = IMM_ZEXT; end
          OP_XORI:  begin dec_aluop = EXE_XORI_OP;  dec_alusel = EXE_RES_LOGIC;      dec_imm_sel = IMM_ZEXT; end
          OP_LUI:   begin dec_aluop = EXE_LUI_OP;   dec_alusel = EXE_RES_LOGIC;      dec_imm_sel = IMM_LUI;  end
          OP_ADDIU: begin dec_aluop = EXE_ADDIU_OP; dec_alusel = EXE_RES_ARITHMETIC; dec_imm_sel = IMM_SEXT; end
          OP_SLTI:  begin dec_aluop = EXE_SLTI_OP;  dec_alusel = EXE_RES_ARITHMETIC; dec_imm_sel = IMM_SEXT; end
          OP_SLTIU: begin dec_aluop = EXE_SLTIU_OP; dec_alusel = EXE_RES_ARITHMETIC; dec_imm_sel = IMM_SEXT; end
          default:  begin
            dec_aluop = EXE_LW_OP; dec_alusel = EXE_RES_LOAD_STORE;
            dec_imm_sel = IMM_SEXT; dec_load = 1'b1;
          end
        endcase
      end
      OP_PREF: ;
      default: dec_inv = 1'b1;
    endcase
  end

  logic [DATA_W-1:0] imm;
  always_comb begin
    imm = '0;
    case (dec_imm_sel)
      IMM_SEXT:  imm = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]};
      IMM_ZEXT:  imm[15:0] = inst_i[15:0];
      IMM_LUI:   imm[31:0] = {inst_i[15:0], 16'h0};
      IMM_SHAMT: imm[4:0]  = sa;
      default:   imm = '0;
    endcase
  end

  assign rf_raddr1_o = rs;
  assign rf_raddr2_o = rt;

  logic [DATA_W-1:0] op1, op2;
  logic              haz1, haz2;

  id_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_mux1 (
    .addr_i(rs), .read_en_i(dec_r1), .rf_data_i(rf_rdata1_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .fwd_pending_i(fwd_pending_i), .imm_i(imm), .operand_o(op1), .hazard_o(haz1)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_mux2 (
    .addr_i(rt), .read_en_i(dec_r2), .rf_data_i(rf_rdata2_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .fwd_pending_i(fwd_pending_i), .imm_i(imm), .operand_o(op2), .hazard_o(haz2)
  );

  logic wreg_res, advance, hazard;
  assign wreg_res   = dec_wreg | (dec_movn & (|op2)) | (dec_movz & ~(|op2));
  assign advance    = ex_ready_i | ~ex_valid_o;
  assign hazard     = if_valid_i & (haz1 | haz2);
  assign id_ready_o = flush_i | (advance & ~hazard);

  logic              valid_q, valid_d, wreg_q, wreg_d, load_q, load_d, inv_q, inv_d;
  logic [7:0]        aluop_q, aluop_d;
  logic [2:0]        alusel_q, alusel_d;
  logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
  logic [4:0]        wd_q, wd_d;
  logic [31:0]       pc_q, pc_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  always_comb begin
    valid_d = valid_q;  wreg_d = wreg_q;  load_d = load_q;   inv_d = inv_q;
    aluop_d = aluop_q;  alusel_d = alusel_q;
    reg1_d  = reg1_q;   reg2_d = reg2_q;  wd_d = wd_q;       pc_d = pc_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      valid_d = 1'b0;
      wreg_d  = 1'b0;
    end else if (advance) begin
      if (hazard) begin
        valid_d = 1'b0;
        wreg_d  = 1'b0;
        if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      end else if (if_valid_i) begin
        valid_d = 1'b1;     wreg_d = wreg_res; load_d = dec_load; inv_d = dec_inv;
        aluop_d = dec_aluop; alusel_d = dec_alusel;
        reg1_d  = op1;      reg2_d = op2;      wd_d = dec_wd;     pc_d = pc_i;
      end else begin
        valid_d = 1'b0;
        wreg_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;  wreg_q <= 1'b0;  load_q <= 1'b0;  inv_q <= 1'b0;
      aluop_q <= '0;    alusel_q <= '0;  reg1_q <= '0;    reg2_q <= '0;
      wd_q <= '0;       pc_q <= '0;      stall_cnt_q <= '0;
    end else begin
      valid_q <= valid_d;  wreg_q <= wreg_d;    load_q <= load_d;  inv_q <= inv_d;
      aluop_q <= aluop_d;  alusel_q <= alusel_d; reg1_q <= reg1_d; reg2_q <= reg2_d;
      wd_q <= wd_d;        pc_q <= pc_d;        stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o   = valid_q;
  assign ex_aluop_o   = aluop_q;
  assign ex_alusel_o  = alusel_q;
  assign ex_reg1_o    = reg1_q;
  assign ex_reg2_o    = reg2_q;
  assign ex_wd_o      = wd_q;
  assign ex_wreg_o    = wreg_q;
  assign ex_is_load_o = load_q;
  assign ex_pc_o      = pc_q;
  assign ex_invalid_o = inv_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_id_issue: directed self-checking bench for id_issue.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_id_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i;
  logic [31:0] pc_i, inst_i;
  logic        id_ready_o;
  logic [4:0]  rf_raddr1_o, rf_raddr2_o;
  logic [31:0] rf_rdata1_i, rf_rdata2_i;
  logic [1:0]  fwd_wreg_i, fwd_pending_i;
  logic [9:0]  fwd_wd_i;
  logic [63:0] fwd_wdata_i;
  logic        ex_ready_i, flush_i;
  logic        ex_valid_o, ex_wreg_o, ex_is_load_o, ex_invalid_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [31:0] ex_reg1_o, ex_reg2_o, ex_pc_o;
  logic [4:0]  ex_wd_o;
  logic [15:0] stall_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_issue #(.DATA_W(32), .NUM_FWD(2)) dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .id_ready_o(id_ready_o), .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
    .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .fwd_pending_i(fwd_pending_i), .ex_ready_i(ex_ready_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
    .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o),
    .ex_wreg_o(ex_wreg_o), .ex_is_load_o(ex_is_load_o), .ex_pc_o(ex_pc_o),
    .ex_invalid_o(ex_invalid_o), .stall_cnt_o(stall_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clr_fwd;
    fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0; fwd_pending_i = '0;
  endtask

  // Set one forwarding source k (0 or 1).
  task automatic set_fwd(input int k, input logic [4:0] wd, input logic [31:0] data,
                         input logic pend);
    fwd_wreg_i[k]          = 1'b1;
    fwd_wd_i[k*5 +: 5]     = wd;
    fwd_wdata_i[k*32 +: 32] = data;
    fwd_pending_i[k]       = pend;
  endtask

  initial begin
    rst = 1'b1; if_valid_i = 1'b0; pc_i = '0; inst_i = '0;
    rf_rdata1_i = '0; rf_rdata2_i = '0; ex_ready_i = 1'b1; flush_i = 1'b0;
    clr_fwd();
    tick(); tick();
    check("rst_valid", {31'b0, ex_valid_o}, 32'd0);
    check("rst_wreg",  {31'b0, ex_wreg_o},  32'd0);
    check("rst_stall", {16'b0, stall_cnt_o}, 32'd0);
    check("rst_reg1",  ex_reg1_o, 32'd0);
    rst = 1'b0;

    // ORI $1,$0,0x8000
    if_valid_i = 1'b1; pc_i = 32'h100; inst_i = itype(6'h0D, 5'd0, 5'd1, 16'h8000);
    rf_rdata1_i = 32'hDEAD0000;
    tick();
    check("ori_valid", {31'b0, ex_valid_o}, 32'd1);
    check("ori_reg1",  ex_reg1_o, 32'h0);
    check("ori_reg2",  ex_reg2_o, 32'h8000);
    check("ori_aluop", {24'b0, ex_aluop_o}, 32'h5A);
    check("ori_wd",    {27'b0, ex_wd_o}, 32'd1);
    check("ori_pc",    ex_pc_o, 32'h100);

    // ADDIU $2,$1,0xFFFF with $1 in EX
    pc_i = 32'h104; inst_i = itype(6'h09, 5'd1, 5'd2, 16'hFFFF);
    rf_rdata1_i = 32'h12345678; set_fwd(0, 5'd1, 32'h8000, 1'b0);
    tick();
    check("addiu_reg1",  ex_reg1_o, 32'h8000);
    check("addiu_reg2",  ex_reg2_o, 32'hFFFFFFFF);
    check("addiu_aluop", {24'b0, ex_aluop_o}, 32'h56);
    check("addiu_wreg",  {31'b0, ex_wreg_o}, 32'd1);

    // OR $6,$3,$3 with both sources writing $3: youngest wins
    clr_fwd(); set_fwd(0, 5'd3, 32'hA, 1'b0); set_fwd(1, 5'd3, 32'hB, 1'b0);
    pc_i = 32'h108; inst_i = rtype(5'd3, 5'd3, 5'd6, 5'd0, 6'h25);
    tick();
    check("or_prio_reg1", ex_reg1_o, 32'hA);
    check("or_prio_reg2", ex_reg2_o, 32'hA);
    check("or_aluop",     {24'b0, ex_aluop_o}, 32'h25);

    // OR $7,$0,$3 with a write to $0 in flight: $0 reads as zero
    clr_fwd(); set_fwd(0, 5'd0, 32'h55, 1'b0); set_fwd(1, 5'd3, 32'hB, 1'b0);
    pc_i = 32'h10C; inst_i = rtype(5'd0, 5'd3, 5'd7, 5'd0, 6'h25);
    tick();
    check("zero_reg1", ex_reg1_o, 32'h0);
    check("zero_reg2", ex_reg2_o, 32'hB);

    // Load-use: LW $4 pending in EX, ADDU $5,$4,$4
    clr_fwd(); set_fwd(0, 5'd4, 32'hBAD, 1'b1); set_fwd(1, 5'd4, 32'h99, 1'b0);
    pc_i = 32'h110; inst_i = rtype(5'd4, 5'd4, 5'd5, 5'd0, 6'h21);
    #1;
    check("lu_ready", {31'b0, id_ready_o}, 32'd0);
    tick();
    check("lu_bubble_valid", {31'b0, ex_valid_o}, 32'd0);
    check("lu_bubble_wreg",  {31'b0, ex_wreg_o}, 32'd0);
    check("lu_stall_cnt",    {16'b0, stall_cnt_o}, 32'd1);
    clr_fwd(); set_fwd(1, 5'd4, 32'h77, 1'b0);
    #1;
    check("lu_ready2", {31'b0, id_ready_o}, 32'd1);
    tick();
    check("lu_valid", {31'b0, ex_valid_o}, 32'd1);
    check("lu_reg1",  ex_reg1_o, 32'h77);
    check("lu_reg2",  ex_reg2_o, 32'h77);
    check("lu_aluop", {24'b0, ex_aluop_o}, 32'h21);
    check("lu_stall_after", {16'b0, stall_cnt_o}, 32'd1);

    // Backpressure: XORI $8,$9,0x00F0 held for 3 cycles
    clr_fwd(); ex_ready_i = 1'b0; rf_rdata1_i = 32'h0F0F;
    pc_i = 32'h114; inst_i = itype(6'h0E, 5'd9, 5'd8, 16'h00F0);
    #1;
    check("bp_ready", {31'b0, id_ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_aluop", {24'b0, ex_aluop_o}, 32'h21);
      check("bp_hold_pc",    ex_pc_o, 32'h110);
    end
    ex_ready_i = 1'b1;
    #1;
    check("bp_ready2", {31'b0, id_ready_o}, 32'd1);
    tick();
    check("xori_aluop", {24'b0, ex_aluop_o}, 32'h5B);
    check("xori_reg1",  ex_reg1_o, 32'h0F0F);
    check("xori_reg2",  ex_reg2_o, 32'hF0);
    check("xori_wd",    {27'b0, ex_wd_o}, 32'd8);
    if_valid_i = 1'b0;
    tick();
    check("idle_valid", {31'b0, ex_valid_o}, 32'd0);

    // Flush during a hazard stall
    set_fwd(0, 5'd4, 32'hBAD, 1'b1);
    if_valid_i = 1'b1; pc_i = 32'h118; inst_i = rtype(5'd4, 5'd4, 5'd5, 5'd0, 6'h21);
    tick();
    check("fl_stall_cnt", {16'b0, stall_cnt_o}, 32'd2);
    flush_i = 1'b1;
    #1;
    check("fl_ready", {31'b0, id_ready_o}, 32'd1);
    tick();
    check("fl_valid", {31'b0, ex_valid_o}, 32'd0);
    check("fl_stall_hold", {16'b0, stall_cnt_o}, 32'd2);
    flush_i = 1'b0; clr_fwd();

    // MOVZ $10,$11,$12 with forwarded rt = 0 while RF holds stale non-zero
    rf_rdata2_i = 32'h5; set_fwd(0, 5'd12, 32'h0, 1'b0);
    pc_i = 32'h11C; inst_i = rtype(5'd11, 5'd12, 5'd10, 5'd0, 6'h0A);
    tick();
    check("movz_wreg",   {31'b0, ex_wreg_o}, 32'd1);
    check("movz_alusel", {29'b0, ex_alusel_o}, 32'd3);
    inst_i = rtype(5'd11, 5'd12, 5'd10, 5'd0, 6'h0B);
    tick();
    check("movn_wreg", {31'b0, ex_wreg_o}, 32'd0);
    clr_fwd();

    // Reserved opcode
    inst_i = 32'hFC000000;
    tick();
    check("inv_flag",  {31'b0, ex_invalid_o}, 32'd1);
    check("inv_wreg",  {31'b0, ex_wreg_o}, 32'd0);
    check("inv_valid", {31'b0, ex_valid_o}, 32'd1);

    // SLL $2,$3,5: shamt lands in the rs slot
    rf_rdata2_i = 32'h9; inst_i = rtype(5'd0, 5'd3, 5'd2, 5'd5, 6'h00);
    tick();
    check("sll_reg1",  ex_reg1_o, 32'd5);
    check("sll_reg2",  ex_reg2_o, 32'd9);
    check("sll_aluop", {24'b0, ex_aluop_o}, 32'h7C);
    check("sll_inv",   {31'b0, ex_invalid_o}, 32'd0);

    // LW $4,-4($1)
    rf_rdata1_i = 32'h100; inst_i = itype(6'h23, 5'd1, 5'd4, 16'hFFFC);
    tick();
    check("lw_reg1", ex_reg1_o, 32'h100);
    check("lw_reg2", ex_reg2_o, 32'hFFFFFFFC);
    check("lw_load", {31'b0, ex_is_load_o}, 32'd1);
    check("lw_aluop", {24'b0, ex_aluop_o}, 32'hE3);

    // NOP: valid but no write
    inst_i = 32'h0;
    tick();
    check("nop_wreg", {31'b0, ex_wreg_o}, 32'd0);
    check("nop_inv",  {31'b0, ex_invalid_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_issue.md
# id_issue

Parametrised decode/issue stage for the OpenMIPS pipeline, sitting between the IF/ID register and the EX stage. It decodes one MIPS32 instruction per cycle and resolves operands through an N-source forwarding network, with no forwarding of $0. It detects load-use hazards and inserts bubbles, then registers the result into an internal ID/EX pipeline register under a valid/ready handshake with stall and flush.

## Interface
- DATA_W, 32: datapath width; must be ≥ 32.
- NUM_FWD, 2: number of forwarding sources; index 0 is the youngest (EX), with priority 0 > 1 > … .
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_valid_i  in  1  instruction at input is valid
- pc_i  in  32  PC of the input instruction
- inst_i  in  32  instruction word
- id_ready_o  out  1  input accepted this cycle; upstream holds while 0
- rf_raddr1_o / rf_raddr2_o  out  5 each  register file read addresses, rs/rt
- rf_rdata1_i / rf_rdata2_i  in  DATA_W each  register file read data, same cycle
- fwd_wreg_i  in  NUM_FWD  source k writes a register
- fwd_wd_i  in  5*NUM_FWD  destination register of source k
- fwd_wdata_i  in  DATA_W*NUM_FWD  result of source k
- fwd_pending_i  in  NUM_FWD  result of source k is not yet available (load in flight)
- ex_ready_i  in  1  EX can accept the registered instruction
- flush_i  in  1  kill the input instruction and the ID/EX contents
- ex_valid_o  out  1  ID/EX register holds a real instruction
- ex_aluop_o  out  8  ALU operation
- ex_alusel_o  out  3  result select
- ex_reg1_o / ex_reg2_o  out  DATA_W each  operands
- ex_wd_o  out  5  destination register
- ex_wreg_o  out  1  write enable
- ex_is_load_o  out  1  instruction is LW
- ex_pc_o  out  32  PC of the registered instruction
- ex_invalid_o  out  1  reserved-instruction flag
- stall_cnt_o  out  16  saturating count of load-use stall cycles

## Operation
- Decode set:
  - Logic: OR, AND, XOR, NOR, ORI, ANDI, XORI, LUI.
  - Shift: SLL, SRL, SRA, SLLV, SRLV, SRAV.
  - Arithmetic: ADDU, SUBU, SLT, SLTU, ADDIU, SLTI, SLTIU.
  - Move: MOVN, MOVZ.
  - Load: LW.
  - NOP/SYNC/PREF decode as valid with wreg = 0.
  - Anything else sets ex_invalid_o = 1 with wreg = 0.
- Immediates:
  - Sign-extended for ADDIU, SLTI, SLTIU and LW.
  - Zero-extended for ORI, ANDI and XORI.
  - LUI produces {inst[15:0], 16'h0}, zero-extended to DATA_W.
  - Shift amount inst[10:6] is zero-extended.
  - The immediate is placed in the operand slot whose read flag is 0.
- Destination register: rd for R-type, rt for I-type.
- Operand selection, per read port:
  - Address 0 always yields 0 and never forwards or stalls.
  - Otherwise the lowest-index k with fwd_wreg_i[k] && fwd_wd_i[k] == addr supplies the operand.
  - If no source matches, the operand is rf_rdata.
  - Unused ports yield the immediate.
- Load-use hazard: an enabled read port whose selected (lowest-index) matching source has fwd_pending_i = 1. Lower-priority sources are never used instead.
- MOVN/MOVZ: wreg is 1 when the resolved rt operand is non-zero (MOVN) or zero (MOVZ), evaluated after forwarding.

## Timing
- Definitions:
  - advance = ex_ready_i || !ex_valid_o
  - hazard = if_valid_i && load-use hazard
  - id_ready_o = advance && !hazard, or 1 when flush_i
- ID/EX register update at the clock edge, highest priority first:
  - rst: all outputs 0, stall_cnt_o = 0.
  - flush_i: ex_valid_o ← 0; the input is discarded.
  - advance && hazard: bubble (ex_valid_o ← 0, wreg 0); stall_cnt_o increments, saturating at 0xFFFF.
  - advance && if_valid_i: load the decoded instruction, ex_valid_o ← 1.
  - advance && !if_valid_i: ex_valid_o ← 0.
  - !advance: hold all ID/EX contents.
- Latency: an instruction accepted in cycle t appears on ex_* in cycle t+1.
- Hazard stalls last while the pending flag persists. Typically this is 1 cycle: LW moves from EX to MEM and becomes a non-pending source at index 1.
- Payload fields are don't-care when ex_valid_o = 0, except wreg, which is 0.
- Reset mid-stall: the stall is dropped and counting restarts from 0.

## Structure
- Shared package `openmips_pkg` holds opcodes, funct codes, EXE_*_OP ALU op codes, EXE_RES_* select codes and the NOPRegAddr constant.
- Sub-module `id_fwd_mux`, one instance per read port, takes (addr, read_en, rf data, fwd vectors, imm) and produces (operand, hazard).
- The top level contains the decoder, the ID/EX register, the handshake logic and the stall counter.

## Test plan
- ORI $1,$0,0x8000 then ADDIU $2,$1,0xFFFF, with $1 in EX (source 0) → ex_reg1_o = 0x8000, ex_reg2_o = 0xFFFFFFFF, aluop ADDIU.
- Sources 0 and 1 both write $3 (0xA / 0xB) while OR reads $3 → 0xA is selected. A write to $0 with 0x55 while a read of $0 occurs → 0.
- LW $4 in EX (pending) then ADDU $5,$4,$4 → id_ready_o = 0 for 1 cycle, one bubble, stall_cnt_o = 1. Next cycle the value arrives from source 1 and is issued.
- ex_ready_i = 0 for 3 cycles with a valid instruction → ex_* held stable, id_ready_o = 0, no instruction lost or duplicated.
- flush_i during a hazard stall → ex_valid_o = 0 next cycle, stall_cnt_o unchanged.
- MOVZ with forwarded rt = 0 → wreg = 1. Opcode 6'h3F → ex_invalid_o = 1, wreg = 0.
